// File: rtl/esc_lpdt_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : esc_lpdt_rx_pkg
// Description : Shared definitions for the escape-mode LPDT receiver and
//               transmitter. It holds the LP line-state encodings ({p,n}),
//               the LPDT entry command, the error codes and the receiver
//               FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package esc_lpdt_rx_pkg;

  // LP line states, encoded as {Dp, Dn}
  localparam logic [1:0] c_LP11 = 2'b11;
  localparam logic [1:0] c_LP10 = 2'b10;
  localparam logic [1:0] c_LP01 = 2'b01;
  localparam logic [1:0] c_LP00 = 2'b00;

  // Escape command that selects Low-Power Data Transmission
  localparam logic [7:0] c_LPDT_CMD = 8'hE1;

  // Error codes reported with lpdt_rx_err
  localparam logic [1:0] c_ERR_ENTRY   = 2'd0;  // bad entry sequence
  localparam logic [1:0] c_ERR_CMD     = 2'd1;  // command other than LPDT
  localparam logic [1:0] c_ERR_SEQ     = 2'd2;  // illegal state / partial byte
  localparam logic [1:0] c_ERR_TIMEOUT = 2'd3;  // line stuck too long

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_ENT_10  = 4'd1,
    S_ENT_00A = 4'd2,
    S_ENT_01  = 4'd3,
    S_ENT_00B = 4'd4,
    S_CMD     = 4'd5,
    S_DATA    = 4'd6,
    S_EXIT    = 4'd7,   // LP-10 seen in DATA: either a '1' bit or Mark-1
    S_DRAIN   = 4'd8
  } lpdt_state_e;

endpackage
`default_nettype wire

// File: rtl/esc_lpdt_rx_lp_line_filter.sv
`default_nettype none
// ============================================================================
// Module      : lp_line_filter
// Description : Two-flop synchronizer followed by a deglitch filter for the
//               D0 LP line pair. A new raw state is accepted only after it
//               has been sampled GLITCH_CYC times in a row.
// Ports       : clk, rst_n    - clock, synchronous active-low reset
//               lp_p_i/lp_n_i - asynchronous LP receiver outputs
//               line_o        - accepted line state {p,n}
//               chg_o         - one-cycle pulse when line_o has just changed
// Revision    : 1.0 - initial release
// ============================================================================
module lp_line_filter #(
  parameter int GLITCH_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lp_p_i,
  input  logic       lp_n_i,
  output logic [1:0] line_o,
  output logic       chg_o
);
  import esc_lpdt_rx_pkg::*;

  localparam int RUN_W = (GLITCH_CYC < 2) ? 1 : $clog2(GLITCH_CYC + 1);
  localparam logic [RUN_W-1:0] c_RUN_MAX = RUN_W'(GLITCH_CYC);

  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       prev_q;      // raw state of the previous cycle
  logic [RUN_W-1:0] run_q, run_d;
  logic [1:0]       line_q, line_d;
  logic             chg_q, chg_d;

  // run_d counts the current raw sample, saturating at GLITCH_CYC
  always_comb begin
    run_d  = RUN_W'(1);
    line_d = line_q;
    chg_d  = 1'b0;
    if (sync2_q == prev_q) begin
      run_d = (run_q == c_RUN_MAX) ? run_q : run_q + RUN_W'(1);
    end
    if ((run_d >= c_RUN_MAX) && (sync2_q != line_q)) begin
      line_d = sync2_q;
      chg_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= c_LP11;
      sync2_q <= c_LP11;
      prev_q  <= c_LP11;
      run_q   <= '0;
      line_q  <= c_LP11;
      chg_q   <= 1'b0;
    end else begin
      sync1_q <= {lp_p_i, lp_n_i};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      run_q   <= run_d;
      line_q  <= line_d;
      chg_q   <= chg_d;
    end
  end

  assign line_o = line_q;
  assign chg_o  = chg_q;

endmodule
`default_nettype wire

// File: rtl/esc_lpdt_rx.sv
`default_nettype none
// ============================================================================
// Module      : esc_lpdt_rx
// Description : Escape-mode Low-Power Data Transmission receiver. Detects the
//               escape entry sequence, decodes the spaced-one-hot command
//               (must be LPDT), then delivers data bytes LSB-first until
//               Mark-1 plus Stop. Protocol violations and timeouts are
//               reported with an error pulse and code.
// Ports       : clk, rst_n          - clock, synchronous active-low reset
//               lp_d0_p, lp_d0_n    - asynchronous LP receiver outputs
//               lpdt_rx_vld/_data   - received byte strobe and value
//               lpdt_rx_sop         - first byte of the packet
//               lpdt_rx_done        - clean end of packet
//               lpdt_rx_err/_code   - error strobe and cause
//               lpdt_rx_busy        - escape sequence in progress
// Revision    : 1.0 - initial release
// ============================================================================
module esc_lpdt_rx #(
  parameter int GLITCH_CYC  = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lp_d0_p,
  input  logic       lp_d0_n,
  output logic       lpdt_rx_vld,
  output logic [7:0] lpdt_rx_data,
  output logic       lpdt_rx_sop,
  output logic       lpdt_rx_done,
  output logic       lpdt_rx_err,
  output logic [1:0] lpdt_rx_err_code,
  output logic       lpdt_rx_busy
);
  import esc_lpdt_rx_pkg::*;

  localparam int TMO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] c_TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [1:0]  line;          // accepted line state
  logic        chg;           // accepted state changed this cycle
  logic [1:0]  line_prev_q;   // accepted state before the current one

  lpdt_state_e state_q, state_d;
  logic [7:0]  sh_q, sh_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic        sop_pend_q, sop_pend_d;
  logic [7:0]  data_q, data_d;
  logic        vld_q, vld_d;
  logic        sop_q, sop_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic        w_bit;
  logic [7:0]  w_cmd_byte;
  logic [7:0]  w_data_byte;
  logic [1:0]  w_ent_next;

  lp_line_filter #(
    .GLITCH_CYC (GLITCH_CYC)
  ) u_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .lp_p_i (lp_d0_p),
    .lp_n_i (lp_d0_n),
    .line_o (line),
    .chg_o  (chg)
  );

  // A bit completes on LP-00; its value is given by the marker before it
  assign w_bit       = (line_prev_q == c_LP10);
  assign w_cmd_byte  = {sh_q[6:0], w_bit};   // command: MSB first
  assign w_data_byte = {w_bit, sh_q[7:1]};   // data: LSB first

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    bitcnt_d   = bitcnt_q;
    sop_pend_d = sop_pend_q;
    data_d     = data_q;
    vld_d      = 1'b0;
    sop_d      = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = 2'd0;
    w_ent_next = c_LP00;

    case (state_q)
      S_IDLE: begin
        sh_d       = '0;
        bitcnt_d   = '0;
        sop_pend_d = 1'b0;
        if (chg && line == c_LP10 && line_prev_q == c_LP11) begin
          state_d = S_ENT_10;
        end
      end

      S_ENT_10, S_ENT_00A, S_ENT_01: begin
        w_ent_next = (state_q == S_ENT_00A) ? c_LP01 : c_LP00;
        if (chg) begin
          if (line == w_ent_next) begin
            case (state_q)
              S_ENT_10:  state_d = S_ENT_00A;
              S_ENT_00A: state_d = S_ENT_01;
              default:   state_d = S_ENT_00B;
            endcase
          end else begin
            err_d      = 1'b1;
            err_code_d = c_ERR_ENTRY;
            state_d    = (line == c_LP11) ? S_IDLE : S_DRAIN;
          end
        end
      end

      // ENT_00B moves straight on to CMD; a change arriving in that very
      // cycle is decoded exactly as CMD would decode it.
      S_ENT_00B, S_CMD: begin
        if (state_q == S_ENT_00B) begin
          state_d = S_CMD;
        end
        if (chg) begin
          if (line == c_LP00) begin
            sh_d     = w_cmd_byte;
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              if (w_cmd_byte == c_LPDT_CMD) begin
                state_d    = S_DATA;
                sh_d       = '0;
                sop_pend_d = 1'b1;
              end else begin
                err_d      = 1'b1;
                err_code_d = c_ERR_CMD;
                state_d    = S_DRAIN;
              end
            end
          end else if (line == c_LP11) begin
            err_d      = 1'b1;
            err_code_d = c_ERR_SEQ;
            state_d    = S_IDLE;
          end else if (line_prev_q != c_LP00) begin
            // marker directly after a marker
            err_d      = 1'b1;
            err_code_d = c_ERR_SEQ;
            state_d    = S_DRAIN;
          end
        end
      end

      S_DATA, S_EXIT: begin
        if (chg) begin
          if (line == c_LP00) begin
            sh_d     = w_data_byte;
            bitcnt_d = bitcnt_q + 3'd1;
            state_d  = S_DATA;
            if (bitcnt_q == 3'd7) begin
              data_d     = w_data_byte;
              vld_d      = 1'b1;
              sop_d      = sop_pend_q;
              sop_pend_d = 1'b0;
            end
          end else if (line == c_LP11) begin
            // Stop: clean only after Mark-1 on a byte boundary
            state_d = S_IDLE;
            if (state_q == S_EXIT && bitcnt_q == 3'd0) begin
              done_d = 1'b1;
            end else begin
              err_d      = 1'b1;
              err_code_d = c_ERR_SEQ;
            end
          end else if (state_q == S_DATA && line_prev_q == c_LP00) begin
            if (line == c_LP10) begin
              state_d = S_EXIT;
            end
          end else begin
            err_d      = 1'b1;
            err_code_d = c_ERR_SEQ;
            state_d    = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        if (line == c_LP11) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Timeout watchdog; DRAIN is silent so it is not timed
    if (state_q == S_IDLE || state_q == S_DRAIN || chg) begin
      tmo_d = '0;
    end else if (tmo_q == c_TMO_LAST) begin
      tmo_d      = '0;
      err_d      = 1'b1;
      err_code_d = c_ERR_TIMEOUT;
      state_d    = S_DRAIN;
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      line_prev_q <= c_LP11;
      sh_q        <= '0;
      bitcnt_q    <= '0;
      sop_pend_q  <= 1'b0;
      data_q      <= '0;
      vld_q       <= 1'b0;
      sop_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      line_prev_q <= line;
      sh_q        <= sh_d;
      bitcnt_q    <= bitcnt_d;
      sop_pend_q  <= sop_pend_d;
      data_q      <= data_d;
      vld_q       <= vld_d;
      sop_q       <= sop_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      tmo_q       <= tmo_d;
    end
  end

  assign lpdt_rx_vld      = vld_q;
  assign lpdt_rx_data     = data_q;
  assign lpdt_rx_sop      = sop_q;
  assign lpdt_rx_done     = done_q;
  assign lpdt_rx_err      = err_q;
  assign lpdt_rx_err_code = err_code_q;
  assign lpdt_rx_busy     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_esc_lpdt_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_esc_lpdt_rx
// Description : Scoreboard bench for esc_lpdt_rx. Stimulus tasks drive the
//               LP line pair and push the expected output events; a monitor
//               pops and compares whenever vld, done or err pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_esc_lpdt_rx;

  localparam int GLITCH_CYC  = 2;
  localparam int TIMEOUT_CYC = 4096;
  localparam int HOLD        = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lp_p = 1'b1;
  logic       lp_n = 1'b1;
  logic       vld, sop, done, err, busy;
  logic [7:0] data;
  logic [1:0] code;

  always #5 clk = ~clk;

  esc_lpdt_rx #(
    .GLITCH_CYC  (GLITCH_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .lp_d0_p          (lp_p),
    .lp_d0_n          (lp_n),
    .lpdt_rx_vld      (vld),
    .lpdt_rx_data     (data),
    .lpdt_rx_sop      (sop),
    .lpdt_rx_done     (done),
    .lpdt_rx_err      (err),
    .lpdt_rx_err_code (code),
    .lpdt_rx_busy     (busy)
  );

  // kind: 0 = byte, 1 = done, 2 = error
  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       sop;
    logic [1:0] code;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec  = 0;
  int  n_miss = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", nm, act, req);
    end
  endtask

  task automatic exp_byte(input logic [7:0] d, input logic s);
    ev_t e;
    e.kind = 0; e.data = d; e.sop = s; e.code = 2'd0;
    exp_q.push_back(e);
  endtask

  task automatic exp_done();
    ev_t e;
    e.kind = 1; e.data = 8'h00; e.sop = 1'b0; e.code = 2'd0;
    exp_q.push_back(e);
  endtask

  task automatic exp_err(input logic [1:0] c);
    ev_t e;
    e.kind = 2; e.data = 8'h00; e.sop = 1'b0; e.code = c;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [1:0] st, input int n);
    {lp_p, lp_n} = st;
    repeat (n) @(posedge clk);
  endtask

  task automatic send_entry();
    drive(2'b10, HOLD); drive(2'b00, HOLD); drive(2'b01, HOLD); drive(2'b00, HOLD);
  endtask

  task automatic send_bit(input logic b);
    drive(b ? 2'b10 : 2'b01, HOLD);
    drive(2'b00, HOLD);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    for (int i = 7; i >= 0; i--) send_bit(c[i]);
  endtask

  task automatic send_byte(input logic [7:0] d);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
  endtask

  task automatic send_stop();
    drive(2'b10, HOLD);
    drive(2'b11, HOLD);
  endtask

  task automatic wait_drain(input string nm);
    int k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      @(posedge clk);
      k++;
    end
    repeat (8) @(posedge clk);
    chk({nm, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (vld || done || err) begin
        int  kind;
        ev_t e;
        chk("one_pulse", 32'(vld) + 32'(done) + 32'(err), 1);
        kind = vld ? 0 : (done ? 1 : 2);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_pulse: got kind %0d data %0h code %0d, want none",
                   kind, data, code);
        end else begin
          e = exp_q.pop_front();
          chk("kind", kind, e.kind);
          if (e.kind == 0) begin
            chk("data", data, e.data);
            chk("sop", sop, e.sop);
          end
          if (e.kind == 2) chk("err_code", code, e.code);
        end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no end of test, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fork
      monitor();
    join_none

    // Reset values
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_vld", vld, 0);
    chk("rst_data", data, 8'h00);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    drive(2'b11, 10);

    // Single byte packet
    exp_byte(8'hA5, 1'b1); exp_done();
    send_entry(); send_cmd(8'hE1); send_byte(8'hA5); send_stop();
    wait_drain("single");
    chk("single_busy", busy, 0);
    chk("single_data_held", data, 8'hA5);

    // Four byte packet, sop only on the first
    exp_byte(8'h05, 1'b1); exp_byte(8'h29, 1'b0);
    exp_byte(8'h00, 1'b0); exp_byte(8'h1C, 1'b0); exp_done();
    send_entry(); send_cmd(8'hE1);
    send_byte(8'h05); send_byte(8'h29); send_byte(8'h00); send_byte(8'h1C);
    send_stop();
    wait_drain("multi");

    // Zero-byte packet
    exp_done();
    send_entry(); send_cmd(8'hE1); send_stop();
    wait_drain("empty");

    // ULPS command is not LPDT
    exp_err(2'd1);
    send_entry(); send_cmd(8'h1E);
    wait_drain("ulps");
    chk("ulps_busy_drain", busy, 1);
    drive(2'b11, 2 * HOLD);
    chk("ulps_busy_idle", busy, 0);

    // 1-cycle LP-11 glitch inside bit 2 (an LP-10 marker) of 0x3C
    exp_byte(8'h3C, 1'b1); exp_done();
    send_entry(); send_cmd(8'hE1);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        drive(2'b10, 2); drive(2'b11, 1); drive(2'b10, 3); drive(2'b00, HOLD);
      end else begin
        send_bit(logic'((8'h3C >> i) & 8'h01));
      end
    end
    send_stop();
    wait_drain("glitch");

    // Stop after 5 bits of a byte
    exp_err(2'd2);
    send_entry(); send_cmd(8'hE1);
    for (int i = 0; i < 5; i++) send_bit(logic'(i & 1));
    send_stop();
    wait_drain("partial");
    chk("partial_busy", busy, 0);

    // Bad entry: LP-01 directly after LP-10
    exp_err(2'd0);
    drive(2'b10, HOLD); drive(2'b01, HOLD);
    wait_drain("bad_entry");
    drive(2'b11, 2 * HOLD);
    chk("bad_entry_busy", busy, 0);

    // Line stuck at LP-00 in DATA
    exp_err(2'd3);
    send_entry(); send_cmd(8'hE1);
    drive(2'b00, TIMEOUT_CYC + 20);
    wait_drain("timeout");
    chk("timeout_busy_drain", busy, 1);
    drive(2'b11, 2 * HOLD);
    chk("timeout_busy_idle", busy, 0);

    // Reset mid-byte: nothing may pulse, everything clears
    send_entry(); send_cmd(8'hE1);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_rst_data", data, 8'h00);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sop", sop, 0);
    chk("mid_rst_code", code, 2'd0);
    drive(2'b11, 3);
    rst_n = 1'b1;
    drive(2'b11, 10);
    chk("post_rst_busy", busy, 0);

    // A fresh entry works after reset
    exp_byte(8'h5A, 1'b1); exp_done();
    send_entry(); send_cmd(8'hE1); send_byte(8'h5A); send_stop();
    wait_drain("recover");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
